lamp_conflict_monitor: RTL and testbench

- Receiving end of the traffic-light controller's lamp interface.
- Watches GRN1/YLW1/RED1 and GRN2/YLW2/RED2 as driven to the intersection and tracks each direction's phase sequence.
- Detects unsafe or illegal sequences; latches the first fault with a code and counts completed signal cycles.
- Sits beside the controller as an independent safety checker; it has no feedback path into the controller.

---
 rtl/lamp_conflict_monitor_if.sv | 34 +++
 rtl/lamp_conflict_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_lamp_conflict_monitor.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lamp_conflict_monitor_if.sv
// Lamp bus between the traffic-light controller and anything that observes the lamps.
//   fm             flash-mode indication from the controller (1 = flashing, checks suspended)
//   grn1/ylw1/red1 direction-1 lamps
//   grn2/ylw2/red2 direction-2 lamps
// master: the controller driving the lamps; slave: a receiver such as the conflict monitor.
interface lamp_conflict_monitor_if;
  logic fm;
  logic grn1;
  logic ylw1;
  logic red1;
  logic grn2;
  logic ylw2;
  logic red2;

  modport master (
    output fm,
    output grn1,
    output ylw1,
    output red1,
    output grn2,
    output ylw2,
    output red2
  );

  modport slave (
    input fm,
    input grn1,
    input ylw1,
    input red1,
    input grn2,
    input ylw2,
    input red2
  );
endinterface

// File: rtl/lamp_conflict_monitor.sv
// Independent safety checker on the intersection lamp bus. It tracks the phase sequence of
// both directions, latches the first unsafe or illegal condition with a code and counts
// completed direction-1 signal cycles. There is no path back into the controller.
//
// Ports:
//   ck          clock, all state on the rising edge
//   clr         synchronous active-high reset, discards all state including a latched fault
//   lamps       lamp bus (slave modport): fm and the six lamps
//   fault       sticky fault flag
//   fault_code  code of the first fault: 1 conflict, 2 skip, 3 short yellow, 4 multi, 5 dark
//   ph1, ph2    tracked phase per direction: 0 unknown, 1 green, 2 yellow, 3 red
//   cycles      completed direction-1 cycles (legal red->green moves), saturating
//
// Pipeline: the lamps and fm are registered first; phases, counters and faults update from
// those registers, so a lamp change on the pins shows on the outputs two edges later.
module lamp_conflict_monitor #(
  parameter int unsigned MIN_YLW  = 2,
  parameter int unsigned MAX_DARK = 3,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned CYC_W    = 8
) (
  input  logic                   ck,
  input  logic                   clr,
  lamp_conflict_monitor_if.slave lamps,
  output logic                   fault,
  output logic [2:0]             fault_code,
  output logic [1:0]             ph1,
  output logic [1:0]             ph2,
  output logic [CYC_W-1:0]       cycles
);

  typedef enum logic [1:0] {
    PhUnk = 2'd0,
    PhGrn = 2'd1,
    PhYlw = 2'd2,
    PhRed = 2'd3
  } phase_e;

  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MinYlw  = CNT_W'(MIN_YLW);
  localparam logic [CNT_W-1:0] MaxDark = CNT_W'(MAX_DARK);
  localparam logic [CYC_W-1:0] CycMax  = {CYC_W{1'b1}};
  localparam logic [CYC_W-1:0] CycOne  = CYC_W'(1);

  // Stage 1: raw lamp capture, {grn, ylw, red} per direction.
  logic       fm_q;
  logic [2:0] gyr_q [2];

  // Stage 2: tracking state.
  phase_e           ph_q     [2];
  phase_e           ph_d     [2];
  logic [CNT_W-1:0] dwell_q  [2];
  logic [CNT_W-1:0] dwell_d  [2];
  logic [CNT_W-1:0] dark_q   [2];
  logic [CNT_W-1:0] dark_d   [2];
  logic             fault_q;
  logic             fault_d;
  logic [2:0]       code_q;
  logic [2:0]       code_d;
  logic [CYC_W-1:0] cycles_q;
  logic [CYC_W-1:0] cycles_d;

  // Per-direction decode of the registered lamps.
  phase_e col      [2];  // PhUnk when not exactly one lamp is lit
  logic   multi    [2];
  logic   dark_now [2];

  // Fault conditions seen this cycle, indexed by fault code.
  logic [5:1] hit;

  function automatic phase_e decode_colour(input logic [2:0] gyr);
    phase_e c;
    unique case (gyr)
      3'b100:  c = PhGrn;
      3'b010:  c = PhYlw;
      3'b001:  c = PhRed;
      default: c = PhUnk;
    endcase
    return c;
  endfunction

  function automatic logic legal_move(input phase_e from, input phase_e to);
    return ((from == PhGrn) && (to == PhYlw)) ||
           ((from == PhYlw) && (to == PhRed)) ||
           ((from == PhRed) && (to == PhGrn));
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      col[d]      = decode_colour(gyr_q[d]);
      // Clearing the lowest set bit leaves something only if two or more lamps are lit.
      multi[d]    = (gyr_q[d] & (gyr_q[d] - 3'd1)) != 3'd0;
      dark_now[d] = gyr_q[d] == 3'd0;
    end
  end

  // Next-state for phase trackers, counters and the fault latch.
  always_comb begin
    ph_d     = ph_q;
    dwell_d  = dwell_q;
    dark_d   = dark_q;
    cycles_d = cycles_q;
    fault_d  = fault_q;
    code_d   = code_q;
    hit      = '0;

    if (fm_q) begin
      // Flashing: forget the sequence, keep any latched fault.
      for (int d = 0; d < 2; d++) begin
        ph_d[d]    = PhUnk;
        dwell_d[d] = '0;
        dark_d[d]  = '0;
      end
    end else begin
      // Conflict looks at raw lamps so a green+yellow multi still conflicts with a green.
      hit[1] = (gyr_q[0][2] | gyr_q[0][1]) & (gyr_q[1][2] | gyr_q[1][1]);

      for (int d = 0; d < 2; d++) begin
        if (multi[d]) begin
          hit[4] = 1'b1;
        end

        if (dark_now[d]) begin
          if (dark_q[d] != CntMax) begin
            dark_d[d] = dark_q[d] + CntOne;
          end
          if (dark_d[d] == MaxDark) begin
            hit[5] = 1'b1;
          end
        end else begin
          dark_d[d] = '0;
        end

        if (col[d] != PhUnk) begin
          if (ph_q[d] == PhUnk) begin
            // Acquisition: take the first valid colour without a sequence check.
            ph_d[d]    = col[d];
            dwell_d[d] = CntOne;
          end else if (col[d] == ph_q[d]) begin
            if (dwell_q[d] != CntMax) begin
              dwell_d[d] = dwell_q[d] + CntOne;
            end
          end else begin
            if (!legal_move(ph_q[d], col[d])) begin
              hit[2] = 1'b1;
            end
            if ((ph_q[d] == PhYlw) && (col[d] == PhRed) && (dwell_q[d] < MinYlw)) begin
              hit[3] = 1'b1;
            end
            ph_d[d]    = col[d];
            dwell_d[d] = CntOne;
          end
        end
      end

      if ((ph_q[0] == PhRed) && (col[0] == PhGrn) && (cycles_q != CycMax)) begin
        cycles_d = cycles_q + CycOne;
      end

      // First fault wins; within a cycle the lowest code wins.
      if (!fault_q && (hit != '0)) begin
        fault_d = 1'b1;
        if (hit[1]) begin
          code_d = 3'd1;
        end else if (hit[2]) begin
          code_d = 3'd2;
        end else if (hit[3]) begin
          code_d = 3'd3;
        end else if (hit[4]) begin
          code_d = 3'd4;
        end else begin
          code_d = 3'd5;
        end
      end
    end
  end

  always_ff @(posedge ck) begin
    if (clr) begin
      fm_q     <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= 3'd0;
      cycles_q <= '0;
      for (int d = 0; d < 2; d++) begin
        gyr_q[d]   <= 3'd0;
        ph_q[d]    <= PhUnk;
        dwell_q[d] <= '0;
        dark_q[d]  <= '0;
      end
    end else begin
      fm_q     <= lamps.fm;
      gyr_q[0] <= {lamps.grn1, lamps.ylw1, lamps.red1};
      gyr_q[1] <= {lamps.grn2, lamps.ylw2, lamps.red2};
      fault_q  <= fault_d;
      code_q   <= code_d;
      cycles_q <= cycles_d;
      for (int d = 0; d < 2; d++) begin
        ph_q[d]    <= ph_d[d];
        dwell_q[d] <= dwell_d[d];
        dark_q[d]  <= dark_d[d];
      end
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign ph1        = ph_q[0];
  assign ph2        = ph_q[1];
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Directed and random stimulus for lamp_conflict_monitor, checked every edge against a
// behavioural model of the monitoring rules plus explicit expected values at key points.
module tb_lamp_conflict_monitor;

  localparam int MinYlw  = 2;
  localparam int MaxDark = 3;
  localparam int Sat     = 255;

  localparam bit [2:0] G = 3'b100;
  localparam bit [2:0] Y = 3'b010;
  localparam bit [2:0] R = 3'b001;
  localparam bit [2:0] D = 3'b000;

  logic       ck;
  logic       clr;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] ph1;
  logic [1:0] ph2;
  logic [7:0] cycles;

  lamp_conflict_monitor_if lif ();

  lamp_conflict_monitor #(
    .MIN_YLW (MinYlw),
    .MAX_DARK(MaxDark),
    .CNT_W   (8),
    .CYC_W   (8)
  ) dut (
    .ck        (ck),
    .clr       (clr),
    .lamps     (lif),
    .fault     (fault),
    .fault_code(fault_code),
    .ph1       (ph1),
    .ph2       (ph2),
    .cycles    (cycles)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int total = 0;
  int bad   = 0;

  // Model state: colours as 0 none, 1 green, 2 yellow, 3 red.
  int m_s1 [2];
  int m_s1fm;
  int m_ph [2];
  int m_dw [2];
  int m_dk [2];
  int m_fault;
  int m_code;
  int m_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic apply(input bit [2:0] d1, input bit [2:0] d2, input bit f);
    lif.grn1 = d1[2];
    lif.ylw1 = d1[1];
    lif.red1 = d1[0];
    lif.grn2 = d2[2];
    lif.ylw2 = d2[1];
    lif.red2 = d2[0];
    lif.fm   = f;
  endtask

  function automatic int lowest(input int cur, input int c);
    return (cur == 0 || c < cur) ? c : cur;
  endfunction

  // One rising edge of the model, using the pins as they were at that edge.
  task automatic model_edge();
    int g [2];
    int y [2];
    int n [2];
    int col [2];
    int best;
    if (clr) begin
      m_fault = 0; m_code = 0; m_cyc = 0; m_s1fm = 0;
      for (int d = 0; d < 2; d++) begin
        m_ph[d] = 0; m_dw[d] = 0; m_dk[d] = 0; m_s1[d] = 0;
      end
      return;
    end
    best = 0;
    for (int d = 0; d < 2; d++) begin
      g[d]   = (m_s1[d] >> 2) & 1;
      y[d]   = (m_s1[d] >> 1) & 1;
      n[d]   = g[d] + y[d] + (m_s1[d] & 1);
      col[d] = (n[d] != 1) ? 0 : (g[d] == 1) ? 1 : (y[d] == 1) ? 2 : 3;
    end
    if (m_s1fm != 0) begin
      for (int d = 0; d < 2; d++) begin
        m_ph[d] = 0; m_dw[d] = 0; m_dk[d] = 0;
      end
    end else begin
      if ((g[0] | y[0]) != 0 && (g[1] | y[1]) != 0) best = lowest(best, 1);
      for (int d = 0; d < 2; d++) begin
        if (n[d] > 1) best = lowest(best, 4);
        if (n[d] == 0) begin
          m_dk[d] = (m_dk[d] < Sat) ? m_dk[d] + 1 : Sat;
          if (m_dk[d] == MaxDark) best = lowest(best, 5);
        end else begin
          m_dk[d] = 0;
        end
        if (col[d] != 0) begin
          if (m_ph[d] == 0) begin
            m_ph[d] = col[d];
            m_dw[d] = 1;
          end else if (col[d] == m_ph[d]) begin
            m_dw[d] = (m_dw[d] < Sat) ? m_dw[d] + 1 : Sat;
          end else begin
            // The legal successor of colour p in G->Y->R->G is p%3+1.
            if (col[d] != (m_ph[d] % 3) + 1) best = lowest(best, 2);
            if (m_ph[d] == 2 && col[d] == 3 && m_dw[d] < MinYlw) best = lowest(best, 3);
            if (d == 0 && m_ph[d] == 3 && col[d] == 1 && m_cyc < Sat) m_cyc++;
            m_ph[d] = col[d];
            m_dw[d] = 1;
          end
        end
      end
      if (m_fault == 0 && best != 0) begin
        m_fault = 1;
        m_code  = best;
      end
    end
    m_s1[0] = {29'd0, lif.grn1, lif.ylw1, lif.red1};
    m_s1[1] = {29'd0, lif.grn2, lif.ylw2, lif.red2};
    m_s1fm  = lif.fm ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
    model_edge();
    chk("model_fault", fault, m_fault);
    chk("model_code", fault_code, m_code);
    chk("model_ph1", ph1, m_ph[0]);
    chk("model_ph2", ph2, m_ph[1]);
    chk("model_cycles", cycles, m_cyc);
  endtask

  task automatic drive(input bit [2:0] d1, input bit [2:0] d2, input int n);
    apply(d1, d2, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  function automatic bit [2:0] rand_gyr();
    int k;
    bit [2:0] v;
    k = $urandom_range(0, 9);
    if (k <= 6) v = 3'b001 << $urandom_range(0, 2);
    else if (k <= 8) v = 3'b000;
    else v = 3'($urandom_range(0, 7));
    return v;
  endfunction

  bit [2:0] seq1 [7];
  int       exp1 [7];
  bit [2:0] r1;
  bit [2:0] r2;
  bit       rf;

  initial begin
    seq1 = '{G, G, Y, Y, R, R, G};
    exp1 = '{1, 1, 2, 2, 3, 3, 1};

    // Reset with random lamps on the pins.
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tick();
    end
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_ph1", ph1, 0);
    chk("rst_ph2", ph2, 0);
    chk("rst_cycles", cycles, 0);
    clr = 1'b0;

    // Legal direction-1 cycle, phase visible two edges after the pins.
    for (int i = 0; i < 7; i++) begin
      apply(seq1[i], R, 1'b0);
      tick();
      if (i >= 1) chk("seq_ph1", ph1, exp1[i-1]);
    end
    drive(G, R, 1);
    chk("seq_ph1_last", ph1, exp1[6]);
    chk("seq_ph2", ph2, 3);
    chk("seq_cycles", cycles, 1);
    chk("seq_fault", fault, 0);

    // Conflict: both green, then a long dark spell must not overwrite the code.
    drive(G, G, 2);
    chk("conf_fault", fault, 1);
    chk("conf_code", fault_code, 1);
    drive(D, D, 5);
    chk("conf_hold_code", fault_code, 1);

    // Skipped yellow.
    pulse_clr();
    drive(G, R, 3);
    drive(R, R, 3);
    chk("skip_code", fault_code, 2);

    // One-cycle yellow.
    pulse_clr();
    drive(G, R, 3);
    drive(Y, R, 1);
    drive(R, R, 3);
    chk("short_ylw_code", fault_code, 3);

    // Multi-lit green+yellow against a green: conflict outranks multi.
    pulse_clr();
    drive(G, R, 3);
    drive(G | Y, G, 3);
    chk("prio_code", fault_code, 1);

    // Dark two cycles is tolerated, three is a fault.
    pulse_clr();
    drive(G, R, 3);
    drive(D, R, 2);
    drive(G, R, 3);
    chk("dark2_fault", fault, 0);
    drive(D, R, 3);
    drive(G, R, 3);
    chk("dark3_code", fault_code, 5);

    // Flash mode: flashing yellows on both directions are ignored.
    pulse_clr();
    for (int i = 0; i < 20; i++) begin
      apply((i % 2 == 0) ? Y : D, (i % 2 == 0) ? Y : D, 1'b1);
      tick();
    end
    chk("flash_fault", fault, 0);
    chk("flash_ph1", ph1, 0);
    chk("flash_ph2", ph2, 0);
    drive(R, G, 3);
    chk("reacq_ph1", ph1, 3);
    chk("reacq_ph2", ph2, 1);
    chk("reacq_fault", fault, 0);

    // Latched fault cleared by a one-cycle clr, then CYCLES saturation.
    drive(R, R, 3);
    chk("pre_clr_fault", fault, 1);
    pulse_clr();
    chk("clr_fault", fault, 0);
    chk("clr_cycles", cycles, 0);
    for (int i = 0; i < 300; i++) begin
      drive(G, R, 1);
      drive(Y, R, 2);
      drive(R, R, 1);
    end
    drive(G, R, 2);
    chk("sat_cycles", cycles, 255);
    chk("sat_fault", fault, 0);

    // Random traffic, including flash and occasional clears.
    pulse_clr();
    r1 = G;
    r2 = R;
    rf = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 30) r1 = rand_gyr();
      if ($urandom_range(0, 99) < 30) r2 = rand_gyr();
      if ($urandom_range(0, 99) < 3) rf = ~rf;
      clr = ($urandom_range(0, 199) == 0);
      apply(r1, r2, rf);
      tick();
    end
    clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
